// File: rtl/noc_pkg.sv
// Shared NoC types: core word and router flit widths, lanes per flit.
// Used by the router, this adapter and their benches.
package noc_pkg;
  localparam int WORD_W = 64;
  localparam int LANES  = 4;
  localparam int FLIT_W = WORD_W * LANES;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO with async reset; storage resets to zero so the head
// reads as zero while empty after reset. Push when full succeeds only with a pop.
module noc_flit_fifo
  import noc_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  flit_t         push_data,
  input  logic          pop,
  output flit_t         head,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          drop
);

  logic [DEPTH-1:0][FLIT_W-1:0] mem;
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic                         full, push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/noc_ip_adapter.sv
// NPU core <-> router IP port adapter: packs 64b words into 256b flits on TX,
// buffers and unpacks flits on RX. The router never back-pressures.
module noc_ip_adapter #(
  parameter  int WORD_W   = noc_pkg::WORD_W,
  parameter  int FLIT_W   = noc_pkg::FLIT_W,
  parameter  int RX_DEPTH = 4,
  localparam int CW       = $clog2(RX_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] core_tx_data,
  input  logic              core_tx_valid,
  input  logic              core_tx_last,
  output logic              core_tx_ready,
  input  logic              tx_hold,
  output logic [FLIT_W-1:0] ip_in_data,
  output logic              ip_in_en,
  input  logic [FLIT_W-1:0] ip_out_data,
  input  logic              ip_out_en,
  output logic [WORD_W-1:0] core_rx_data,
  output logic              core_rx_valid,
  input  logic              core_rx_ready,
  output logic [CW-1:0]     rx_count,
  output logic              rx_overflow
);

  localparam int               LANES     = FLIT_W / WORD_W;
  localparam int               LW        = $clog2(LANES);
  localparam logic [LW-1:0]    LANE_LAST = LW'(LANES - 1);

  // ---------------- TX packer + issue register ----------------
  logic [LANES-1:0][WORD_W-1:0] stage;
  logic [LW-1:0]                tx_lane;
  logic                         tx_pending, tx_acc, tx_issue;

  assign core_tx_ready = ~tx_pending;
  assign tx_acc        = core_tx_valid & ~tx_pending;
  assign tx_issue      = tx_pending & ~tx_hold;

  // Accept and issue are exclusive (accept needs !pending), so the stage
  // clear on issue never collides with a lane write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage      <= '0;
      tx_lane    <= '0;
      tx_pending <= 1'b0;
      ip_in_data <= '0;
      ip_in_en   <= 1'b0;
    end else begin
      ip_in_en <= tx_issue;
      if (tx_issue) begin
        ip_in_data <= stage;
        stage      <= '0;
        tx_pending <= 1'b0;
      end
      if (tx_acc) begin
        stage[tx_lane] <= core_tx_data;
        if (tx_lane == LANE_LAST || core_tx_last) begin
          tx_pending <= 1'b1;
          tx_lane    <= '0;
        end else begin
          tx_lane <= tx_lane + 1'b1;
        end
      end
    end
  end

  // ---------------- RX FIFO + unpack ----------------
  noc_pkg::flit_t               fifo_head;
  logic [LANES-1:0][WORD_W-1:0] head_lanes;
  logic [LW-1:0]                rx_lane;
  logic                         fifo_empty, fifo_drop, rx_hs, rx_pop;

  noc_flit_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ip_out_en),
    .push_data (ip_out_data),
    .pop       (rx_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (rx_count),
    .drop      (fifo_drop)
  );

  assign head_lanes    = fifo_head;
  assign core_rx_valid = ~fifo_empty;
  assign core_rx_data  = head_lanes[rx_lane];
  assign rx_hs         = core_rx_valid & core_rx_ready;
  assign rx_pop        = rx_hs & (rx_lane == LANE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_lane     <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_hs)
        rx_lane <= rx_pop ? '0 : rx_lane + 1'b1;
      if (fifo_drop)
        rx_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_ip_adapter.sv
// Randomized bench for noc_ip_adapter against a queue-based message/flit model.
module tb_noc_ip_adapter;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  core_tx_data = '0;
  logic         core_tx_valid = 1'b0, core_tx_last = 1'b0, tx_hold = 1'b0;
  logic         core_tx_ready;
  logic [255:0] ip_in_data, ip_out_data = '0;
  logic         ip_in_en, ip_out_en = 1'b0;
  logic [63:0]  core_rx_data;
  logic         core_rx_valid, core_rx_ready = 1'b0;
  logic [2:0]   rx_count;
  logic         rx_overflow;

  noc_ip_adapter #(.WORD_W(64), .FLIT_W(256), .RX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .core_tx_data(core_tx_data), .core_tx_valid(core_tx_valid),
    .core_tx_last(core_tx_last), .core_tx_ready(core_tx_ready),
    .tx_hold(tx_hold), .ip_in_data(ip_in_data), .ip_in_en(ip_in_en),
    .ip_out_data(ip_out_data), .ip_out_en(ip_out_en),
    .core_rx_data(core_rx_data), .core_rx_valid(core_rx_valid),
    .core_rx_ready(core_rx_ready), .rx_count(rx_count), .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // reference model state
  logic [63:0]  words[$];
  logic [255:0] rxq[$];
  logic [255:0] m_flit, m_data;
  logic         m_pending, m_en, m_ovf, m_zero;
  int           m_rxl;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    words.delete(); rxq.delete();
    m_flit = '0; m_data = '0; m_pending = 0; m_en = 0; m_ovf = 0;
    m_zero = 1; m_rxl = 0;
  endtask

  task automatic model_step();
    bit hs, pop;
    m_en = m_pending && !tx_hold;
    if (m_en) begin m_data = m_flit; m_pending = 0; end
    else if (core_tx_valid && !m_pending) begin
      words.push_back(core_tx_data);
      if (words.size() == 4 || core_tx_last) begin
        m_flit = '0;
        foreach (words[i]) m_flit[i*64 +: 64] = words[i];
        words.delete();
        m_pending = 1;
      end
    end
    hs  = (rxq.size() != 0) && core_rx_ready;
    pop = hs && (m_rxl == 3);
    if (hs) m_rxl = pop ? 0 : m_rxl + 1;
    if (pop) void'(rxq.pop_front());
    if (ip_out_en) begin
      if (rxq.size() < DEPTH) begin rxq.push_back(ip_out_data); m_zero = 0; end
      else m_ovf = 1;
    end
  endtask

  task automatic check_all();
    logic [255:0] h;
    chk("tx_ready", core_tx_ready, !m_pending);
    chk("ip_in_en", ip_in_en, m_en);
    chk("ip_in_data", ip_in_data, m_data);
    chk("rx_valid", core_rx_valid, rxq.size() != 0);
    if (rxq.size() != 0) begin
      h = rxq[0];
      chk("rx_data", core_rx_data, h[m_rxl*64 +: 64]);
    end else if (m_zero) chk("rx_data_rst", core_rx_data, '0);
    chk("rx_count", rx_count, rxq.size());
    chk("rx_overflow", rx_overflow, m_ovf);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit v, input logic [63:0] d, input bit last, input bit hold,
                       input bit oen, input bit rrdy);
    core_tx_valid = v; core_tx_data = d; core_tx_last = last; tx_hold = hold;
    ip_out_en = oen; core_rx_ready = rrdy;
    ip_out_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic rand_drive();
    drive($urandom_range(9) < 7, {$urandom, $urandom}, $urandom_range(4) == 0,
          $urandom_range(9) < 3, $urandom_range(9) < 4, $urandom_range(9) < 6);
  endtask

  initial begin
    model_reset();
    repeat (2) cycle();
    @(negedge clk); rst = 1'b0;
    check_all();
    repeat (2) cycle();

    // four-word flit, then single-word message with last
    for (int i = 1; i <= 4; i++) begin drive(1, 64'(i), 0, 0, 0, 0); cycle(); end
    drive(0, 0, 0, 0, 0, 0); repeat (3) cycle();
    drive(1, 64'hA, 1, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0); repeat (3) cycle();

    // pending flit held off by tx_hold
    for (int i = 5; i <= 8; i++) begin drive(1, 64'(i), 0, 1, 0, 0); cycle(); end
    drive(0, 0, 0, 1, 0, 0); repeat (3) cycle();
    drive(0, 0, 0, 0, 0, 0); repeat (3) cycle();

    // fill FIFO, push on the lane-3 pop, then overflow
    repeat (4) begin drive(0, 0, 0, 0, 1, 0); cycle(); end
    repeat (3) begin drive(0, 0, 0, 0, 0, 1); cycle(); end
    drive(0, 0, 0, 0, 1, 1); cycle();
    drive(0, 0, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 1, 0); cycle();
    drive(0, 0, 0, 0, 0, 1); repeat (20) cycle();

    repeat (400) begin rand_drive(); cycle(); end

    // mid-operation reset: two TX words staged, one RX flit buffered
    drive(0, 0, 0, 0, 0, 1); repeat (20) cycle();
    drive(1, 64'h11, 0, 0, 1, 0); cycle();
    drive(1, 64'h22, 0, 0, 0, 0); cycle();
    rst = 1'b1; #1;
    model_reset();
    check_all();
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) cycle();
    rst = 1'b0;
    repeat (2) cycle();
    for (int i = 1; i <= 4; i++) begin drive(1, 64'(i + 32), 0, 0, 0, 0); cycle(); end
    drive(0, 0, 0, 0, 0, 0); repeat (3) cycle();

    repeat (200) begin rand_drive(); cycle(); end
    drive(0, 0, 0, 0, 0, 1); repeat (24) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
